// File: rtl/menu_led_pio_pkg.sv
// Shared definitions for the LED PIO block: register word addresses and pulse FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a; no ports.
package menu_led_pio_pkg;

   // Avalon-MM word addresses; anything not listed reads 0 and ignores writes
   localparam logic [2:0] ADDR_DATA   = 3'd0;  // R/W output data register
   localparam logic [2:0] ADDR_OUTSET = 3'd4;  // W   set bits in data
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;  // W   clear bits in data
   localparam logic [2:0] ADDR_PULSE  = 3'd6;  // R/W timed pulse mask
   localparam logic [2:0] ADDR_STATUS = 3'd7;  // R   bit0 = pulse busy

   typedef enum logic {
      PULSE_IDLE    = 1'b0,
      PULSE_PULSING = 1'b1
   } pulse_state_t;

   // Counter width able to hold cycles-1; never below one bit so a
   // one-clock pulse still has a legal counter.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/menu_led_pio_pulse_timer.sv
// Timed pulse mask: holds mask bits high for PULSE_CYCLES clocks after the last nonzero load.
// Latency: pulse_mask/busy update on the clock edge that samples load.
// Backpressure: none; a load is always accepted (retriggers and extends the pulse).
// Ports: clk, reset_n (async active-low), load (nonzero pulse write strobe),
//        mask_in (bits to pulse), pulse_mask (bits currently pulsed), busy (FSM in PULSING).
module pulse_timer
   import menu_led_pio_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] mask_in,
   output logic [WIDTH-1:0] pulse_mask,
   output logic             busy
);

   localparam int               CNT_W      = cnt_width(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_CYCLES - 1);

   pulse_state_t     state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= PULSE_IDLE;
         cnt        <= '0;
         pulse_mask <= '0;
      end else begin
         case (state)
            PULSE_IDLE: begin
               if (load) begin
                  pulse_mask <= mask_in;
                  cnt        <= CNT_RELOAD;
                  state      <= PULSE_PULSING;
               end
            end
            PULSE_PULSING: begin
               if (load) begin
                  cnt <= CNT_RELOAD;
                  // On the expiry cycle the old bits are already done, so the
                  // new write replaces them instead of extending them.
                  if (cnt == '0) pulse_mask <= mask_in;
                  else           pulse_mask <= pulse_mask | mask_in;
               end else if (cnt == '0) begin
                  pulse_mask <= '0;
                  state      <= PULSE_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state      <= PULSE_IDLE;
               cnt        <= '0;
               pulse_mask <= '0;
            end
         endcase
      end
   end

   assign busy = (state == PULSE_PULSING);

endmodule

// File: rtl/menu_led_pio.sv
// LED PIO slave: data register with set/clear aliases plus a retriggerable timed pulse overlay.
// Latency: writes reach out_port one clock after the write edge; readdata is registered, 1 clock.
// Backpressure: none; every access completes in one cycle (no waitrequest).
// Ports: clk, reset_n (async active-low), address/chipselect/write_n/writedata (Avalon-MM slave),
//        readdata (registered, zero-extended), out_port (data | pulse_mask).
module menu_led_pio
   import menu_led_pio_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               PULSE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic             pulse_load;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] pulse_mask;
   logic             busy;
   logic [31:0]      rd_next;
   logic             wdata_unused;

   assign wr    = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];
   // Upper write-data bits beyond WIDTH carry no meaning for this block.
   assign wdata_unused = ^writedata;

   // A zero pulse write must not start or retrigger anything.
   assign pulse_load = wr && (address == ADDR_PULSE) && (wdata != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= RESET_VALUE;
      end else if (wr) begin
         case (address)
            ADDR_DATA:   data <= wdata;
            ADDR_OUTSET: data <= data | wdata;
            ADDR_OUTCLR: data <= data & ~wdata;
            default:     ;
         endcase
      end
   end

   pulse_timer #(
      .WIDTH        (WIDTH),
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (pulse_load),
      .mask_in    (wdata),
      .pulse_mask (pulse_mask),
      .busy       (busy)
   );

   // Read mux is sampled every clock regardless of chipselect.
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:   rd_next[WIDTH-1:0] = data;
         ADDR_PULSE:  rd_next[WIDTH-1:0] = pulse_mask;
         ADDR_STATUS: rd_next[0]         = busy;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   assign out_port = data | pulse_mask;

endmodule

// File: doc/menu_led_pio.md
MENU_LED_PIO -- requirements
Module: menu_led_pio

Interface
REQ-001 Parameter WIDTH, default 8: output port width, 1..32.
REQ-002 Parameter RESET_VALUE, default 0: reset value of the data register.
REQ-003 Parameter PULSE_CYCLES, default 50000: pulse duration in clocks, minimum 1.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 readdata  output  32  registered read data, zero-extended.
REQ-011 out_port  output  WIDTH  driven value, equal to data | pulse_mask.

Function
REQ-012 Address map SHALL be: 0 data (R/W), 4 outset (W), 5 outclear (W), 6 pulse (R/W), 7 status (R); all others read 0 and ignore writes.
REQ-013 A write is chipselect=1 and write_n=0; state SHALL update on the same clock edge.
REQ-014 Write to address 0 SHALL load data <= writedata[WIDTH-1:0].
REQ-015 Write to address 4 SHALL set data <= data | writedata.
REQ-016 Write to address 5 SHALL clear data <= data & ~writedata.
REQ-017 out_port SHALL reflect a write on the clock after the write edge, with no additional latency.
REQ-018 Pulse FSM SHALL have states IDLE and PULSING, with a counter of ceil(log2(PULSE_CYCLES)) bits.
REQ-019 A nonzero write to address 6 in IDLE SHALL set pulse_mask <= writedata, load counter <= PULSE_CYCLES-1, and enter PULSING.
REQ-020 A nonzero write to address 6 in PULSING SHALL OR writedata into pulse_mask and reload the counter.
REQ-021 In PULSING with counter=0 and no pulse write, the block SHALL clear pulse_mask and return to IDLE; otherwise the counter SHALL decrement.
REQ-022 Pulse write on the expiry cycle SHALL win: pulse_mask <= writedata only, counter reloaded, state remains PULSING.
REQ-023 A zero write to address 6 SHALL have no effect.
REQ-024 Each pulse bit SHALL be high on out_port for exactly PULSE_CYCLES clocks after the last pulse write.
REQ-025 readdata SHALL register the address mux every clock, independent of chipselect: read latency 1.
REQ-026 Read mux: address 0 returns data; 6 returns pulse_mask; 7 returns bit0=busy (state==PULSING) and zeros elsewhere.
REQ-027 Writes to data, outset and outclear SHALL NOT affect pulse_mask or the FSM, and pulse writes SHALL NOT affect data.

Reset
REQ-028 While reset_n=0: data=RESET_VALUE, pulse_mask=0, counter=0, state=IDLE, readdata=0, out_port=RESET_VALUE.
REQ-029 Reset asserted mid-pulse SHALL abort the pulse immediately (asynchronously), with no resumption after release.

Structure
REQ-030 The shared package SHALL hold address constants (ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR, ADDR_PULSE, ADDR_STATUS) and the pulse-state enum.
REQ-031 Sub-module pulse_timer SHALL own the FSM and counter (inputs: load, mask_in; outputs: pulse_mask, busy); the register file and read mux SHALL stay at top level.

Verification
REQ-032 Write 0xA5 to addr 0, then read addr 0 -> out_port=0xA5 one clock after the write; readdata=0x000000A5 one clock after the address is presented.
REQ-033 From data=0xA5: write 0x0F to addr 4, then 0x81 to addr 5 -> out_port=0xAF, then 0x2E.
REQ-034 With PULSE_CYCLES=4 and data=0: write 0x01 to addr 6 -> out_port bit0 high exactly 4 clocks; status busy=1 during the pulse, then 0.
REQ-035 With PULSE_CYCLES=4: write 0x01, then 0x02 at pulse cycle 2 -> out_port=0x03 for 4 clocks from the second write; no gap on bit0.
REQ-036 With PULSE_CYCLES=4: write 0x04 exactly on the expiry cycle -> mask=0x04 only, 4 further clocks; assert reset_n=0 mid-pulse -> out_port=RESET_VALUE immediately, busy=0.
